sub_share_sched: RTL and testbench
==================================

Name: sub_share_sched

Overview:
- Schedules one shared WIDTH-bit subtract datapath (DIFF = A - B - CI, CO = borrow out) among NREQ independent requesters.
- Arbitration is round-robin; each requester uses a valid/ready handshake.
- A single registered output stage returns each result tagged with the requester ID.
- The block sits between client engines and the lone subtractor, so only one subtractor instance exists per cluster.

Parameters:
- WIDTH, 8, operand and result width.
- NREQ, 4, number of requesters (power of two, 2..8).
- IDW, $clog2(NREQ), requester ID width.
- CNTW, 16, width of the completed-operation counter.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  NREQ  per-requester operation request.
- req_ready  out  NREQ  per-requester accept; at most one bit high per cycle.
- req_a  in  NREQ*WIDTH  minuend, requester i in slice [i*WIDTH +: WIDTH].
- req_b  in  NREQ*WIDTH  subtrahend, same slicing.
- req_ci  in  NREQ  borrow-in per requester.
- rsp_valid  out  1  result register holds a valid result.
- rsp_ready  in  1  consumer accepts result.
- rsp_diff  out  WIDTH  registered A - B - CI, mod 2^WIDTH.
- rsp_co  out  1  registered borrow: 1 iff A < B + CI (unsigned).
- rsp_id  out  IDW  index of the requester that issued the result.
- op_count  out  CNTW  number of accepted operations; wraps at 2^CNTW.

Behaviour:
- Reset (async, immediate): rsp_valid=0, rsp_diff=0, rsp_co=0, rsp_id=0, op_count=0, rr_ptr=0. req_ready is forced to 0 while rst is high.
- can_issue = !rsp_valid || rsp_ready. The output slot drains and refills in the same cycle, giving full throughput of 1 op/cycle.
- Grant (combinational):
  - When can_issue and any req_valid is high, pick the first valid index scanning rr_ptr, rr_ptr+1, ... mod NREQ.
  - Assert req_ready only for that index. All other req_ready bits are 0.
  - When can_issue=0, all req_ready=0.
- Accept = req_valid[g] && req_ready[g]. On accept, at the next edge:
  - load rsp_diff/rsp_co from the granted operands;
  - set rsp_id=g and rsp_valid=1;
  - set op_count+=1;
  - set rr_ptr=(g+1) mod NREQ.
- If rsp_valid && rsp_ready with no accept: rsp_valid -> 0 next cycle. rsp_diff/co/id hold their last values (don't-care but stable).
- If rsp_valid && !rsp_ready: all rsp_* outputs are held stable, and there are no grants.
- rr_ptr moves only on accept. Idle cycles do not rotate it.
- Latency: accept in cycle N -> rsp_valid in N+1.
- Arithmetic:
  - Compute a WIDTH+1-bit result {0,A} - {0,B} - CI.
  - rsp_diff = low WIDTH bits; rsp_co = bit WIDTH (1 = borrow).
  - Edge case: A=0, B=2^WIDTH-1, CI=1 gives diff=0, co=1.
- Requesters must hold a_/b_/ci stable while valid && !ready. The block does not latch operands before accept.
- A requester dropping valid without a handshake is legal: it is simply not granted.
- op_count wraps from 2^CNTW-1 to 0 with no flag.
- Reset mid-operation: a pending result is discarded and rr_ptr returns to 0. Requesters re-present after reset.
- FSM: implicit two-state output slot.
  - EMPTY -> FULL on accept.
  - FULL -> EMPTY on rsp_ready with no accept.
  - FULL -> FULL on rsp_ready with accept, or on !rsp_ready.

Decomposition:
- Shared package sub_sched_pkg holds:
  - WIDTH/NREQ/IDW/CNTW defaults;
  - typedef operand_t (logic [WIDTH-1:0]);
  - typedef req_id_t (logic [IDW-1:0]);
  - typedef struct rsp_t {diff, co, id}.
- One natural sub-module: rr_arbiter (NREQ-wide round-robin priority pick).
  - Inputs: req vector, rr_ptr, enable.
  - Outputs: one-hot grant and encoded index.
- The subtractor is a single expression in the top level, so exactly one subtractor is synthesized.

Test Plan:
- Single op: req0 a=0x05 b=0x07 ci=0 -> req_ready[0]=1 same cycle; next cycle rsp_valid=1, diff=0xFE, co=1, id=0, op_count=1.
- Borrow-in: req2 a=0x10 b=0x01 ci=1 -> diff=0x0E, co=0, id=2. Also a=0x00 b=0xFF ci=1 -> diff=0x00, co=1.
- Fairness: all 4 valid continuously, rsp_ready=1 -> grant sequence 0,1,2,3,0,1 on consecutive cycles; one result per cycle; op_count increments every cycle.
- Backpressure: rsp_ready=0 for 5 cycles with a result held -> rsp_* stable, req_ready=0 throughout. Raise rsp_ready -> the held result drains and the next grant is accepted in the same cycle.
- Pointer hold: only req3 valid (accepted, rr_ptr=0), idle 3 cycles, then req1 and req3 valid -> req1 granted first.
- Async reset: assert rst mid-cycle while rsp_valid=1 -> rsp_valid=0 and op_count=0 immediately. After release, with req1 and req2 valid -> req1 granted (rr_ptr=0).

Source files
------------

// File: rtl/sub_sched_pkg.sv
// Shared defaults and result types for the shared-subtractor scheduler.
package sub_sched_pkg;

    localparam int WIDTH_DEF = 8;
    localparam int NREQ_DEF  = 4;
    localparam int IDW_DEF   = $clog2(NREQ_DEF);
    localparam int CNTW_DEF  = 16;

    typedef logic [WIDTH_DEF-1:0] operand_t;
    typedef logic [IDW_DEF-1:0]   req_id_t;

    typedef struct packed {
        operand_t diff;
        logic     co;
        req_id_t  id;
    } rsp_t;

endpackage

// File: rtl/sub_share_sched_rr_arbiter.sv
// Round-robin priority pick: first requester at or after ptr, wrapping modulo NREQ.
module rr_arbiter #(
    parameter int NREQ = 4,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  ptr,
    input  logic            en,
    output logic [NREQ-1:0] gnt,
    output logic [IDW-1:0]  idx
);

    logic           found_s;
    logic [IDW-1:0] cand_s;

    // Scan ptr, ptr+1, ... ; IDW-bit addition wraps because NREQ is a power of two.
    always_comb begin
        gnt     = '0;
        idx     = '0;
        found_s = 1'b0;
        cand_s  = '0;
        for (int i = 0; i < NREQ; i++) begin
            cand_s = ptr + IDW'(i);
            if (en && !found_s && req[cand_s]) begin
                gnt[cand_s] = 1'b1;
                idx         = cand_s;
                found_s     = 1'b1;
            end else begin
                found_s = found_s;
            end
        end
    end

endmodule

// File: rtl/sub_share_sched.sv
// Time-shares one subtractor among NREQ requesters with round-robin grants
// and a single registered, ID-tagged result slot.
module sub_share_sched
    import sub_sched_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int NREQ  = NREQ_DEF,
    parameter int IDW   = $clog2(NREQ),
    parameter int CNTW  = CNTW_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req_valid,
    output logic [NREQ-1:0]       req_ready,
    input  logic [NREQ*WIDTH-1:0] req_a,
    input  logic [NREQ*WIDTH-1:0] req_b,
    input  logic [NREQ-1:0]       req_ci,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [WIDTH-1:0]      rsp_diff,
    output logic                  rsp_co,
    output logic [IDW-1:0]        rsp_id,
    output logic [CNTW-1:0]       op_count
);

    logic [IDW-1:0]   rr_ptr_r;
    logic             can_issue_s;
    logic             arb_en_s;
    logic             accept_s;
    logic [NREQ-1:0]  gnt_s;
    logic [IDW-1:0]   gnt_idx_s;
    logic [WIDTH-1:0] sel_a_s;
    logic [WIDTH-1:0] sel_b_s;
    logic             sel_ci_s;
    logic [WIDTH:0]   sub_s;

    // The slot can take a new result when empty or when it drains this cycle.
    assign can_issue_s = !rsp_valid || rsp_ready;
    assign arb_en_s    = can_issue_s && !rst;

    rr_arbiter #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_arb (
        .req (req_valid),
        .ptr (rr_ptr_r),
        .en  (arb_en_s),
        .gnt (gnt_s),
        .idx (gnt_idx_s)
    );

    assign req_ready = gnt_s;
    assign accept_s  = |(req_valid & gnt_s);

    // Route the granted operands into the single shared subtractor.
    always_comb begin
        sel_a_s  = req_a[gnt_idx_s*WIDTH +: WIDTH];
        sel_b_s  = req_b[gnt_idx_s*WIDTH +: WIDTH];
        sel_ci_s = req_ci[gnt_idx_s];
        sub_s    = {1'b0, sel_a_s} - {1'b0, sel_b_s} - {{WIDTH{1'b0}}, sel_ci_s};
    end

    // Output slot, accept counter and round-robin pointer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_valid <= 1'b0;
            rsp_diff  <= '0;
            rsp_co    <= 1'b0;
            rsp_id    <= '0;
            op_count  <= '0;
            rr_ptr_r  <= '0;
        end else if (accept_s) begin
            rsp_valid <= 1'b1;
            rsp_diff  <= sub_s[WIDTH-1:0];
            rsp_co    <= sub_s[WIDTH];
            rsp_id    <= gnt_idx_s;
            op_count  <= op_count + CNTW'(1'b1);
            rr_ptr_r  <= gnt_idx_s + IDW'(1'b1);
        end else if (rsp_ready) begin
            rsp_valid <= 1'b0;
        end else begin
            rsp_valid <= rsp_valid;
        end
    end

endmodule

// File: tb/tb_sub_share_sched.sv
// Self-checking bench for sub_share_sched: scoreboard of expected results
// plus scenario tasks checking grants, latency, backpressure and reset.
module tb_sub_share_sched;
    import sub_sched_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req_valid;
    logic [3:0]  req_ready;
    logic [31:0] req_a;
    logic [31:0] req_b;
    logic [3:0]  req_ci;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [7:0]  rsp_diff;
    logic        rsp_co;
    logic [1:0]  rsp_id;
    logic [15:0] op_count;

    int   n_cmp = 0;
    int   n_err = 0;
    rsp_t sb[$];
    int   gnt_log[$];

    logic [7:0] fa [4] = '{8'h30, 8'h02, 8'hA5, 8'hFF};
    logic [7:0] fb [4] = '{8'h31, 8'h01, 8'h5A, 8'h00};
    logic [3:0] fci    = 4'b1101;

    sub_share_sched dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_ci    (req_ci),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_diff  (rsp_diff),
        .rsp_co    (rsp_co),
        .rsp_id    (rsp_id),
        .op_count  (op_count)
    );

    always #5 clk = ~clk;

    function automatic rsp_t model(input logic [7:0] a, input logic [7:0] b,
                                   input logic ci, input int id);
        int   d;
        rsp_t r;
        d      = int'(a) - int'(b) - (ci ? 1 : 0);
        r.co   = (d < 0);
        r.diff = 8'((d + 512) % 256);
        r.id   = 2'(id);
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input int i, input logic [7:0] a, input logic [7:0] b, input logic ci);
        req_a[i*8 +: 8] = a;
        req_b[i*8 +: 8] = b;
        req_ci[i]       = ci;
    endtask

    // Scoreboard: push on every handshake, pop on every result drain.
    always @(negedge clk) begin
        rsp_t exp_r;
        if (!rst) begin
            n_cmp++;
            if ($countones(req_ready) > 1) begin
                n_err++;
                $display("FAIL onehot: req_ready=%b required at most one bit", req_ready);
            end
            if (rsp_valid && rsp_ready) begin
                n_cmp++;
                if (sb.size() == 0) begin
                    n_err++;
                    $display("FAIL sb_empty: got result id=%0d, none expected", rsp_id);
                end else begin
                    exp_r = sb.pop_front();
                    if ({rsp_diff, rsp_co, rsp_id} !== exp_r) begin
                        n_err++;
                        $display("FAIL sb_result: got diff=%h co=%b id=%0d required diff=%h co=%b id=%0d",
                                 rsp_diff, rsp_co, rsp_id, exp_r.diff, exp_r.co, exp_r.id);
                    end
                end
            end
            for (int i = 0; i < 4; i++) begin
                if (req_valid[i] && req_ready[i]) begin
                    sb.push_back(model(req_a[i*8 +: 8], req_b[i*8 +: 8], req_ci[i], i));
                    gnt_log.push_back(i);
                end
            end
        end
    end

    task automatic test_reset();
        rst       = 1'b1;
        rsp_ready = 1'b1;
        req_valid = 4'hF;
        req_a     = 32'h1234_5678;
        req_b     = 32'h0102_0304;
        req_ci    = 4'h0;
        #1;
        n_cmp++;
        if ({rsp_valid, rsp_diff, rsp_co, rsp_id, op_count, req_ready} !== 32'h0) begin
            n_err++;
            $display("FAIL reset_state: got v=%b d=%h co=%b id=%0d cnt=%0d rdy=%b required all 0",
                     rsp_valid, rsp_diff, rsp_co, rsp_id, op_count, req_ready);
        end
        tick();
        tick();
        n_cmp++;
        if ({rsp_valid, req_ready} !== 5'b0) begin
            n_err++;
            $display("FAIL reset_hold: got v=%b rdy=%b required 0/0000", rsp_valid, req_ready);
        end
        req_valid = 4'h0;
        rst       = 1'b0;
        tick();
    endtask

    task automatic test_single();
        set_op(0, 8'h05, 8'h07, 1'b0);
        req_valid = 4'b0001;
        #1;
        n_cmp++;
        if (req_ready !== 4'b0001) begin
            n_err++;
            $display("FAIL single_ready: got %b required 0001", req_ready);
        end
        tick();
        req_valid = 4'b0000;
        n_cmp++;
        if ({rsp_valid, rsp_diff, rsp_co, rsp_id, op_count} !== {1'b1, 8'hFE, 1'b1, 2'd0, 16'd1}) begin
            n_err++;
            $display("FAIL single_rsp: got v=%b d=%h co=%b id=%0d cnt=%0d required 1/fe/1/0/1",
                     rsp_valid, rsp_diff, rsp_co, rsp_id, op_count);
        end
        tick();
    endtask

    task automatic test_borrow();
        set_op(2, 8'h10, 8'h01, 1'b1);
        req_valid = 4'b0100;
        tick();
        n_cmp++;
        if ({rsp_diff, rsp_co, rsp_id} !== {8'h0E, 1'b0, 2'd2}) begin
            n_err++;
            $display("FAIL borrow_in: got d=%h co=%b id=%0d required 0e/0/2", rsp_diff, rsp_co, rsp_id);
        end
        set_op(2, 8'h00, 8'hFF, 1'b1);
        tick();
        req_valid = 4'b0000;
        n_cmp++;
        if ({rsp_diff, rsp_co, rsp_id, op_count} !== {8'h00, 1'b1, 2'd2, 16'd3}) begin
            n_err++;
            $display("FAIL borrow_edge: got d=%h co=%b id=%0d cnt=%0d required 00/1/2/3",
                     rsp_diff, rsp_co, rsp_id, op_count);
        end
        tick();
    endtask

    task automatic test_pointer_hold();
        set_op(3, 8'h44, 8'h22, 1'b0);
        req_valid = 4'b1000;
        tick();
        req_valid = 4'b0000;
        n_cmp++;
        if ({rsp_valid, rsp_diff, rsp_co, rsp_id} !== {1'b1, 8'h22, 1'b0, 2'd3}) begin
            n_err++;
            $display("FAIL ptr_req3: got v=%b d=%h co=%b id=%0d required 1/22/0/3",
                     rsp_valid, rsp_diff, rsp_co, rsp_id);
        end
        tick();
        tick();
        tick();
        set_op(1, 8'h01, 8'h02, 1'b0);
        req_valid = 4'b1010;
        #1;
        n_cmp++;
        if (req_ready !== 4'b0010) begin
            n_err++;
            $display("FAIL ptr_hold: got req_ready=%b required 0010", req_ready);
        end
        tick();
        n_cmp++;
        if (req_ready !== 4'b1000) begin
            n_err++;
            $display("FAIL ptr_next: got req_ready=%b required 1000", req_ready);
        end
        tick();
        req_valid = 4'b0000;
        tick();
    endtask

    task automatic test_fairness();
        int exp_seq [6] = '{0, 1, 2, 3, 0, 1};
        for (int i = 0; i < 4; i++) set_op(i, fa[i], fb[i], fci[i]);
        gnt_log.delete();
        req_valid = 4'hF;
        for (int k = 1; k <= 6; k++) begin
            tick();
            n_cmp++;
            if ({rsp_valid, op_count} !== {1'b1, 16'(6 + k)}) begin
                n_err++;
                $display("FAIL fair_count: cycle %0d got v=%b cnt=%0d required 1/%0d",
                         k, rsp_valid, op_count, 6 + k);
            end
        end
        n_cmp++;
        if (gnt_log.size() != 6) begin
            n_err++;
            $display("FAIL fair_len: got %0d grants required 6", gnt_log.size());
        end else begin
            for (int k = 0; k < 6; k++) begin
                n_cmp++;
                if (gnt_log[k] != exp_seq[k]) begin
                    n_err++;
                    $display("FAIL fair_order: slot %0d got %0d required %0d", k, gnt_log[k], exp_seq[k]);
                end
            end
        end
    endtask

    task automatic test_back_pressure();
        rsp_t held;
        held      = model(fa[1], fb[1], fci[1], 1);
        rsp_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            #1;
            n_cmp++;
            if ({rsp_valid, rsp_diff, rsp_co, rsp_id, req_ready, op_count} !==
                {1'b1, held, 4'b0000, 16'd12}) begin
                n_err++;
                $display("FAIL bp_hold: cycle %0d got v=%b d=%h co=%b id=%0d rdy=%b cnt=%0d required 1/%h/%b/1/0000/12",
                         k, rsp_valid, rsp_diff, rsp_co, rsp_id, req_ready, op_count, held.diff, held.co);
            end
            tick();
        end
        rsp_ready = 1'b1;
        #1;
        n_cmp++;
        if (req_ready !== 4'b0100) begin
            n_err++;
            $display("FAIL bp_release: got req_ready=%b required 0100", req_ready);
        end
        tick();
        req_valid = 4'b0000;
        n_cmp++;
        if ({rsp_valid, rsp_id, op_count} !== {1'b1, 2'd2, 16'd13}) begin
            n_err++;
            $display("FAIL bp_next: got v=%b id=%0d cnt=%0d required 1/2/13", rsp_valid, rsp_id, op_count);
        end
        tick();
    endtask

    task automatic test_async_reset();
        set_op(0, 8'h80, 8'h7F, 1'b0);
        req_valid = 4'b0001;
        tick();
        req_valid = 4'b0000;
        rsp_ready = 1'b0;
        #3;
        rst = 1'b1;
        sb.delete();
        #1;
        n_cmp++;
        if ({rsp_valid, op_count, req_ready} !== 21'h0) begin
            n_err++;
            $display("FAIL async_rst: got v=%b cnt=%0d rdy=%b required 0/0/0000", rsp_valid, op_count, req_ready);
        end
        tick();
        rst       = 1'b0;
        rsp_ready = 1'b1;
        set_op(1, 8'h09, 8'h03, 1'b1);
        set_op(2, 8'h01, 8'h01, 1'b0);
        req_valid = 4'b0110;
        #1;
        n_cmp++;
        if (req_ready !== 4'b0010) begin
            n_err++;
            $display("FAIL rst_ptr: got req_ready=%b required 0010", req_ready);
        end
        tick();
        req_valid = 4'b0000;
        n_cmp++;
        if ({rsp_valid, rsp_diff, rsp_co, rsp_id, op_count} !== {1'b1, 8'h05, 1'b0, 2'd1, 16'd1}) begin
            n_err++;
            $display("FAIL rst_first: got v=%b d=%h co=%b id=%0d cnt=%0d required 1/05/0/1/1",
                     rsp_valid, rsp_diff, rsp_co, rsp_id, op_count);
        end
        tick();
        tick();
        n_cmp++;
        if (sb.size() != 0 || rsp_valid !== 1'b0) begin
            n_err++;
            $display("FAIL drain: got %0d pending, v=%b required 0 pending, v=0", sb.size(), rsp_valid);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_borrow();
        test_pointer_hold();
        test_fairness();
        test_back_pressure();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
